playback_sequencer: RTL and testbench

PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

---
 rtl/memgame_pkg.sv | 18 +
 rtl/step_timer.sv | 40 ++++
 rtl/playback_sequencer.sv | 139 +++++++++++++
 tb/tb_playback_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memgame_pkg.sv
// Shared definitions for the memory-game playback logic: the sequencer
// state encoding and the width helper used to size index/step/length fields.
package memgame_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      SHOW = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   // ceil(log2(count)), never narrower than one bit so degenerate
   // parameterisations (a single LED, a single step) still get a real vector.
   function automatic int bits_for(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/step_timer.sv
// Two-level timer: a prescaler divides the clock into ticks and a tick
// counter reports when the requested number of ticks has elapsed.
// The expired pulse is high on the final clock of the interval so the
// owner can change state on that same edge; clear restarts the interval.
module step_timer
   import memgame_pkg::*;
#(
   parameter int TICK_LIMIT = 25000,
   parameter int CNT_W      = 5
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [CNT_W-1:0] target,
   output logic             expired
);

   localparam int PRE_W = bits_for(TICK_LIMIT);

   logic [PRE_W-1:0] prescale;
   logic [CNT_W-1:0] tick_count;
   logic             tick;

   assign tick    = (prescale == PRE_W'(TICK_LIMIT - 1));
   assign expired = tick && (tick_count == target - CNT_W'(1));

   // Prescaler wraps on every tick; the tick counter only advances on ticks.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         prescale   <= '0;
         tick_count <= '0;
      end else if (tick) begin
         prescale   <= '0;
         tick_count <= tick_count + CNT_W'(1);
      end else begin
         prescale   <= prescale + PRE_W'(1);
      end
   end

endmodule

// File: rtl/playback_sequencer.sv
// Plays a latched pattern of LED indices: each step is a dark gap followed
// by the step's LED lit, then a one-cycle done pulse. Abort or reset drops
// straight back to idle without a done pulse.
module playback_sequencer
   import memgame_pkg::*;
#(
   parameter int NUM_LEDS   = 4,
   parameter int MAX_LEN    = 16,
   parameter int TICK_LIMIT = 25000,
   parameter int ON_TICKS   = 20,
   parameter int OFF_TICKS  = 10,
   localparam int IDX_W     = bits_for(NUM_LEDS),
   localparam int LEN_W     = bits_for(MAX_LEN + 1),
   localparam int STEP_W    = bits_for(MAX_LEN)
)(
   input  logic                     i_Clk,
   input  logic                     i_Rst,
   input  logic                     i_Start,
   input  logic                     i_Abort,
   input  logic [LEN_W-1:0]         i_Length,
   input  logic [MAX_LEN*IDX_W-1:0] i_Pattern,
   output logic [NUM_LEDS-1:0]      o_LED,
   output logic                     o_Busy,
   output logic                     o_Done,
   output logic [STEP_W-1:0]        o_Step
);

   localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int CNT_W     = bits_for(MAX_TICKS + 1);

   seq_state_t               state;
   logic [MAX_LEN*IDX_W-1:0] pattern_q;
   logic [LEN_W-1:0]         length_q;
   logic [LEN_W-1:0]         eff_length;
   logic [IDX_W-1:0]         cur_index;
   logic [NUM_LEDS-1:0]      show_led;
   logic [CNT_W-1:0]         timer_target;
   logic                     timer_clear;
   logic                     timer_expired;
   logic                     last_step;

   // Requests longer than the pattern storage are clipped to MAX_LEN steps.
   assign eff_length   = (i_Length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_Length;
   assign timer_target = (state == SHOW) ? CNT_W'(ON_TICKS) : CNT_W'(OFF_TICKS);
   // The timer restarts on every state change, and is held at zero outside
   // GAP/SHOW, so each interval is measured from the state's first cycle.
   assign timer_clear  = ((state != GAP) && (state != SHOW)) || i_Abort || timer_expired;
   assign cur_index    = pattern_q[int'(o_Step) * IDX_W +: IDX_W];
   assign last_step    = (LEN_W'(o_Step) == length_q - LEN_W'(1));

   step_timer #(
      .TICK_LIMIT (TICK_LIMIT),
      .CNT_W      (CNT_W)
   ) u_timer (
      .clk     (i_Clk),
      .rst     (i_Rst),
      .clear   (timer_clear),
      .target  (timer_target),
      .expired (timer_expired)
   );

   // One-hot decode of the current step; indices with no matching LED stay dark.
   always_comb begin
      show_led = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         show_led[i] = (int'(cur_index) == i);
      end
   end

   // Sequencer FSM; every output is set on the edge that enters the new state.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state     <= IDLE;
         pattern_q <= '0;
         length_q  <= '0;
         o_LED     <= '0;
         o_Busy    <= 1'b0;
         o_Done    <= 1'b0;
         o_Step    <= '0;
      end else begin
         case (state)
            IDLE: begin
               o_LED  <= '0;
               o_Done <= 1'b0;
               o_Busy <= 1'b0;
               if (i_Start && !i_Abort) begin
                  if (eff_length == '0) begin
                     state  <= DONE;
                     o_Done <= 1'b1;
                  end else begin
                     state     <= GAP;
                     pattern_q <= i_Pattern;
                     length_q  <= eff_length;
                     o_Step    <= '0;
                     o_Busy    <= 1'b1;
                  end
               end
            end
            GAP: begin
               if (i_Abort) begin
                  state  <= IDLE;
                  o_LED  <= '0;
                  o_Busy <= 1'b0;
               end else if (timer_expired) begin
                  state <= SHOW;
                  o_LED <= show_led;
               end
            end
            SHOW: begin
               if (i_Abort) begin
                  state  <= IDLE;
                  o_LED  <= '0;
                  o_Busy <= 1'b0;
               end else if (timer_expired) begin
                  o_LED <= '0;
                  if (last_step) begin
                     state  <= DONE;
                     o_Busy <= 1'b0;
                     o_Done <= 1'b1;
                  end else begin
                     state  <= GAP;
                     o_Step <= o_Step + STEP_W'(1);
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               o_Done <= 1'b0;
               o_LED  <= '0;
               o_Busy <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_playback_sequencer.sv
// Scoreboard bench for playback_sequencer. Two instances share the stimulus:
// one with four LEDs and one with three, so pattern index 3 is a real LED on
// the first and an out-of-range (dark) step on the second. A reference model
// expands each accepted start into its cycle-by-cycle timeline of expected
// outputs; a separate monitor pops one expectation per clock and compares.
module tb_playback_sequencer;

   localparam int NUM_LEDS   = 4;
   localparam int MAX_LEN    = 4;
   localparam int TICK_LIMIT = 2;
   localparam int ON_TICKS   = 2;
   localparam int OFF_TICKS  = 1;
   localparam int IDX_W      = 2;
   localparam int LEN_W      = 3;
   localparam int STEP_W     = 2;
   localparam int PAT_W      = MAX_LEN * IDX_W;

   typedef struct packed {
      logic [3:0]        led4;
      logic [2:0]        led3;
      logic              busy;
      logic              done;
      logic [STEP_W-1:0] step;
   } expect_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [LEN_W-1:0] length;
   logic [PAT_W-1:0] pattern;

   logic [3:0]        led_a;
   logic              busy_a;
   logic              done_a;
   logic [STEP_W-1:0] step_a;
   logic [2:0]        led_b;
   logic              busy_b;
   logic              done_b;
   logic [STEP_W-1:0] step_b;

   expect_t pending[$];
   expect_t scoreboard[$];
   expect_t cur;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   playback_sequencer #(
      .NUM_LEDS   (NUM_LEDS),
      .MAX_LEN    (MAX_LEN),
      .TICK_LIMIT (TICK_LIMIT),
      .ON_TICKS   (ON_TICKS),
      .OFF_TICKS  (OFF_TICKS)
   ) dut (
      .i_Clk     (clk),
      .i_Rst     (rst),
      .i_Start   (start),
      .i_Abort   (abort),
      .i_Length  (length),
      .i_Pattern (pattern),
      .o_LED     (led_a),
      .o_Busy    (busy_a),
      .o_Done    (done_a),
      .o_Step    (step_a)
   );

   playback_sequencer #(
      .NUM_LEDS   (3),
      .MAX_LEN    (MAX_LEN),
      .TICK_LIMIT (TICK_LIMIT),
      .ON_TICKS   (ON_TICKS),
      .OFF_TICKS  (OFF_TICKS)
   ) dut3 (
      .i_Clk     (clk),
      .i_Rst     (rst),
      .i_Start   (start),
      .i_Abort   (abort),
      .i_Length  (length),
      .i_Pattern (pattern),
      .o_LED     (led_b),
      .o_Busy    (busy_b),
      .o_Done    (done_b),
      .o_Step    (step_b)
   );

   // Builds one expected output record; v < 0 means no LED lit.
   function automatic expect_t make_rec(input int v, input logic busy, input logic done, input int step);
      expect_t r;
      r.led4 = '0;
      r.led3 = '0;
      if (v >= 0 && v < 4) r.led4[v] = 1'b1;
      if (v >= 0 && v < 3) r.led3[v] = 1'b1;
      r.busy = busy;
      r.done = done;
      r.step = STEP_W'(step);
      return r;
   endfunction

   // Reference model: decides what the outputs must be after the coming edge.
   task automatic model_step();
      expect_t nxt;
      int      l;
      int      v;
      if (rst) begin
         pending.delete();
         nxt = make_rec(-1, 1'b0, 1'b0, 0);
      end else if (cur.busy && abort) begin
         pending.delete();
         nxt = make_rec(-1, 1'b0, 1'b0, int'(cur.step));
      end else if (pending.size() > 0) begin
         nxt = pending.pop_front();
      end else if (!cur.done && start && !abort) begin
         l = (int'(length) > MAX_LEN) ? MAX_LEN : int'(length);
         if (l == 0) begin
            nxt = make_rec(-1, 1'b0, 1'b1, int'(cur.step));
         end else begin
            for (int s = 0; s < l; s++) begin
               v = int'(pattern[s*IDX_W +: IDX_W]);
               for (int c = 0; c < OFF_TICKS * TICK_LIMIT; c++)
                  pending.push_back(make_rec(-1, 1'b1, 1'b0, s));
               for (int c = 0; c < ON_TICKS * TICK_LIMIT; c++)
                  pending.push_back(make_rec(v, 1'b1, 1'b0, s));
            end
            pending.push_back(make_rec(-1, 1'b0, 1'b1, l - 1));
            nxt = pending.pop_front();
         end
      end else begin
         nxt = make_rec(-1, 1'b0, 1'b0, int'(cur.step));
      end
      cur = nxt;
      scoreboard.push_back(nxt);
   endtask

   // Drives one clock's worth of inputs and records the expected response.
   task automatic applyStimulus(input logic s_rst, input logic s_start, input logic s_abort,
                                input logic [LEN_W-1:0] s_len, input logic [PAT_W-1:0] s_pat);
      @(negedge clk);
      rst     = s_rst;
      start   = s_start;
      abort   = s_abort;
      length  = s_len;
      pattern = s_pat;
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   // Compares both instances against one expected record.
   task automatic checkOutput(input expect_t e);
      vectors++;
      if (led_a !== e.led4 || busy_a !== e.busy || done_a !== e.done || step_a !== e.step) begin
         miscompares++;
         $display("[TB] FAIL dut4 @%0t: got led=%b busy=%b done=%b step=%0d, expected led=%b busy=%b done=%b step=%0d",
                  $time, led_a, busy_a, done_a, step_a, e.led4, e.busy, e.done, e.step);
      end
      vectors++;
      if (led_b !== e.led3 || busy_b !== e.busy || done_b !== e.done || step_b !== e.step) begin
         miscompares++;
         $display("[TB] FAIL dut3 @%0t: got led=%b busy=%b done=%b step=%0d, expected led=%b busy=%b done=%b step=%0d",
                  $time, led_b, busy_b, done_b, step_b, e.led3, e.busy, e.done, e.step);
      end
   endtask

   // Monitor: one expectation is consumed shortly after every rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (scoreboard.size() > 0) checkOutput(scoreboard.pop_front());
      end
   end

   initial begin
      logic [PAT_W-1:0] pat;
      logic [LEN_W-1:0] len;
      logic             r_rst;
      logic             r_start;
      logic             r_abort;

      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      length  = '0;
      pattern = '0;
      cur     = make_rec(-1, 1'b0, 1'b0, 0);

      $display("[TB] reset");
      applyStimulus(1'b1, 1'b1, 1'b1, 3'd2, 8'hFF);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      idle(2);

      $display("[TB] two-step pattern {1,3}");
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 8'b00_00_11_01);
      idle(16);

      $display("[TB] zero length");
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 8'b11_10_01_00);
      idle(4);

      $display("[TB] length clipped to storage");
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd7, 8'b00_01_10_11);
      idle(28);

      $display("[TB] abort during second show, then restart");
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 8'b00_10_01_11);
      idle(9);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
      idle(2);
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 8'b00_10_01_11);
      idle(2);
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 8'b00_10_01_11);
      idle(22);

      $display("[TB] reset mid-show with ignored start pulses");
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 8'b00_00_10_01);
      idle(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd4, 8'b11_11_11_11);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 8'b00_00_00_10);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 8'b00_00_01_10);
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd4, 8'b11_11_11_11);
      idle(14);

      $display("[TB] out-of-range index on the three-LED instance");
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd4, 8'b01_10_11_00);
      idle(27);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 4000; i++) begin
         r_rst   = ($urandom_range(0, 199) == 0);
         r_abort = ($urandom_range(0, 47) == 0);
         r_start = ($urandom_range(0, 5) == 0);
         len     = LEN_W'($urandom_range(0, 7));
         pat     = PAT_W'($urandom);
         applyStimulus(r_rst, r_start, r_abort, len, pat);
      end
      idle(30);

      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
